// File: rtl/sv32_pkg.sv
// Shared Sv32 types: PTE layout, TLB update word, walker states and PTE address helper.
package sv32_pkg;

    localparam int unsigned PAGE_OFFSET_W = 12;
    localparam int unsigned VPN_W         = 10;
    localparam int unsigned PTE_BYTES     = 4;
    localparam int unsigned SATP_PPN_W    = 22;
    localparam int unsigned SV32_PA_W     = 34;
    localparam int unsigned TLB_ASID_W    = 9;
    localparam int unsigned TLB_VPN_W     = 2 * VPN_W;
    localparam int unsigned TLB_UPD_W     = 63;

    typedef struct packed {
        logic [11:0] ppn1;
        logic [9:0]  ppn0;
        logic [1:0]  rsw;
        logic        d;
        logic        a;
        logic        g;
        logic        u;
        logic        x;
        logic        w;
        logic        r;
        logic        v;
    } pte_t;

    // Layout consumed by the sv32 TLB update input.
    typedef struct packed {
        logic                  valid;
        logic                  is_4m;
        logic [TLB_VPN_W-1:0]  vpn;
        logic [TLB_ASID_W-1:0] asid;
        pte_t                  pte;
    } tlb_update_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_L1_REQ,
        S_L1_WAIT,
        S_L0_REQ,
        S_L0_WAIT,
        S_DRAIN,
        S_UPDATE,
        S_FAULT
    } walk_state_e;

    // Table base page plus one word-sized slot per VPN entry; the offset never carries.
    function automatic logic [SV32_PA_W-1:0] pte_addr(input logic [SATP_PPN_W-1:0] ppn,
                                                      input logic [VPN_W-1:0]      vpn);
        return {ppn, PAGE_OFFSET_W'(0)} + SV32_PA_W'(vpn) * SV32_PA_W'(PTE_BYTES);
    endfunction

endpackage

// File: rtl/sv32_pte_classify.sv
// Combinational PTE classifier shared by the data-side and instruction-side walkers.
module sv32_pte_classify
    import sv32_pkg::*;
(
    input  pte_t pte_i,
    input  logic level1_i,
    output logic invalid_c_o,
    output logic leaf_c_o,
    output logic misaligned_c_o
);

    logic unused_pte_bits;

    assign invalid_c_o    = !pte_i.v || (!pte_i.r && pte_i.w);
    assign leaf_c_o       = pte_i.r || pte_i.x;
    // A first-level leaf maps 4 MiB, so its low PPN must be zero.
    assign misaligned_c_o = level1_i && leaf_c_o && (pte_i.ppn0 != '0);

    assign unused_pte_bits = ^{pte_i.ppn1, pte_i.rsw, pte_i.d, pte_i.a, pte_i.g, pte_i.u};

endmodule

// File: rtl/sv32_tlb_refill_walker.sv
// Sv32 two-level page-table walker that turns TLB misses into TLB update words or page faults.
module sv32_tlb_refill_walker
    import sv32_pkg::*;
#(
    parameter int unsigned ASID_W = 9,
    parameter int unsigned PA_W   = 34
)(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  miss_valid_i,
    output logic                  miss_ready_o,
    input  logic [31:0]           miss_vaddr_i,
    input  logic [ASID_W-1:0]     miss_asid_i,
    input  logic [SATP_PPN_W-1:0] satp_ppn_i,
    input  logic                  flush_i,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [PA_W-1:0]       mem_req_addr_o,
    input  logic                  mem_rsp_valid_i,
    input  logic [31:0]           mem_rsp_data_i,
    output logic [TLB_UPD_W-1:0]  update_o,
    output logic                  fault_o,
    output logic [31:0]           fault_vaddr_o
);

    localparam int unsigned VA_W = 32;

    walk_state_e           state_q, state_d;
    logic [VA_W-1:0]       vaddr_q, vaddr_d;
    logic [ASID_W-1:0]     asid_q, asid_d;
    logic [SATP_PPN_W-1:0] satp_q, satp_d;
    logic                  req_valid_q, req_valid_d;
    logic [PA_W-1:0]       req_addr_q, req_addr_d;
    tlb_update_t           update_q, update_d;
    logic                  fault_q, fault_d;
    logic [VA_W-1:0]       fault_va_q, fault_va_d;

    pte_t rsp_pte;
    logic pte_invalid;
    logic pte_leaf;
    logic pte_misaligned;

    assign rsp_pte = pte_t'(mem_rsp_data_i);

    sv32_pte_classify u_classify (
        .pte_i          (rsp_pte),
        .level1_i       (state_q == S_L1_WAIT),
        .invalid_c_o    (pte_invalid),
        .leaf_c_o       (pte_leaf),
        .misaligned_c_o (pte_misaligned)
    );

    // Next-state and next-output logic; outputs are registered one cycle behind the decision.
    always_comb begin
        state_d     = state_q;
        vaddr_d     = vaddr_q;
        asid_d      = asid_q;
        satp_d      = satp_q;
        req_valid_d = 1'b0;
        req_addr_d  = '0;
        update_d    = '0;
        fault_d     = 1'b0;
        fault_va_d  = '0;

        case (state_q)
            S_IDLE: begin
                if (miss_valid_i && !flush_i) begin
                    vaddr_d     = miss_vaddr_i;
                    asid_d      = miss_asid_i;
                    satp_d      = satp_ppn_i;
                    state_d     = S_L1_REQ;
                    req_valid_d = 1'b1;
                    req_addr_d  = PA_W'(pte_addr(satp_ppn_i, miss_vaddr_i[31:22]));
                end
            end
            S_L1_REQ, S_L0_REQ: begin
                if (mem_req_ready_i) begin
                    // An accepted request always owes a response, even when flushed.
                    if (flush_i) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = (state_q == S_L1_REQ) ? S_L1_WAIT : S_L0_WAIT;
                    end
                end else if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    req_valid_d = 1'b1;
                    req_addr_d  = req_addr_q;
                end
            end
            S_L1_WAIT, S_L0_WAIT: begin
                if (flush_i) begin
                    state_d = mem_rsp_valid_i ? S_IDLE : S_DRAIN;
                end else if (mem_rsp_valid_i) begin
                    if (pte_invalid || pte_misaligned || (state_q == S_L0_WAIT && !pte_leaf)) begin
                        state_d    = S_FAULT;
                        fault_d    = 1'b1;
                        fault_va_d = vaddr_q;
                    end else if (pte_leaf) begin
                        state_d        = S_UPDATE;
                        update_d.valid = 1'b1;
                        update_d.is_4m = (state_q == S_L1_WAIT);
                        update_d.vpn   = vaddr_q[31:12];
                        update_d.asid  = TLB_ASID_W'(asid_q);
                        update_d.pte   = rsp_pte;
                    end else begin
                        state_d     = S_L0_REQ;
                        req_valid_d = 1'b1;
                        req_addr_d  = PA_W'(pte_addr({rsp_pte.ppn1, rsp_pte.ppn0}, vaddr_q[21:12]));
                    end
                end
            end
            S_DRAIN: begin
                if (mem_rsp_valid_i) begin
                    state_d = S_IDLE;
                end
            end
            S_UPDATE, S_FAULT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            vaddr_q     <= '0;
            asid_q      <= '0;
            satp_q      <= '0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            update_q    <= '0;
            fault_q     <= 1'b0;
            fault_va_q  <= '0;
        end else begin
            state_q     <= state_d;
            vaddr_q     <= vaddr_d;
            asid_q      <= asid_d;
            satp_q      <= satp_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            update_q    <= update_d;
            fault_q     <= fault_d;
            fault_va_q  <= fault_va_d;
        end
    end

    // Ready must drop in the same cycle as a flush, so it is decoded from state and flush_i.
    assign miss_ready_o    = (state_q == S_IDLE) && !flush_i;
    assign mem_req_valid_o = req_valid_q;
    assign mem_req_addr_o  = req_addr_q;
    assign update_o        = update_q;
    assign fault_o         = fault_q;
    assign fault_vaddr_o   = fault_va_q;

endmodule

// File: tb/tb_sv32_tlb_refill_walker.sv
// Scoreboard bench for the Sv32 refill walker with a latency/backpressure memory responder.
module tb_sv32_tlb_refill_walker;

    localparam int unsigned ASID_W = 9;
    localparam int unsigned PA_W   = 34;

    typedef struct {
        logic [62:0] upd;
        logic        flt;
        logic [31:0] fva;
    } exp_t;

    logic              clk_i;
    logic              rst_i;
    logic              miss_valid_i;
    logic              miss_ready_o;
    logic [31:0]       miss_vaddr_i;
    logic [ASID_W-1:0] miss_asid_i;
    logic [21:0]       satp_ppn_i;
    logic              flush_i;
    logic              mem_req_valid_o;
    logic              mem_req_ready_i;
    logic [PA_W-1:0]   mem_req_addr_o;
    logic              mem_rsp_valid_i;
    logic [31:0]       mem_rsp_data_i;
    logic [62:0]       update_o;
    logic              fault_o;
    logic [31:0]       fault_vaddr_o;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0]     mem [logic [PA_W-1:0]];
    logic [PA_W-1:0] exp_req_q [$];
    exp_t            exp_out_q [$];
    int n_req_exp = 0;
    int n_req_seen = 0;
    int n_out_exp = 0;
    int n_out_seen = 0;
    int stall_cfg = 0;
    int stall_left = 0;
    int rsp_lat = 1;
    int rsp_cnt = 0;
    int cyc = 0;
    int last_rsp_cyc = -10;

    sv32_tlb_refill_walker #(.ASID_W(ASID_W), .PA_W(PA_W)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .miss_valid_i    (miss_valid_i),
        .miss_ready_o    (miss_ready_o),
        .miss_vaddr_i    (miss_vaddr_i),
        .miss_asid_i     (miss_asid_i),
        .satp_ppn_i      (satp_ppn_i),
        .flush_i         (flush_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .update_o        (update_o),
        .fault_o         (fault_o),
        .fault_vaddr_o   (fault_vaddr_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Memory model: programmable ready stall and response latency, one outstanding read.
    initial begin : responder
        logic            acc;
        logic [PA_W-1:0] acc_addr;
        logic [31:0]     rsp_data;
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i  = 32'h0;
        rsp_data        = 32'h0;
        forever begin
            @(negedge clk_i);
            acc      = mem_req_valid_o && mem_req_ready_i && !rst_i;
            acc_addr = mem_req_addr_o;
            @(posedge clk_i);
            #1;
            mem_rsp_valid_i = 1'b0;
            if (acc) begin
                rsp_data   = mem.exists(acc_addr) ? mem[acc_addr] : 32'h0;
                rsp_cnt    = rsp_lat;
                stall_left = stall_cfg;
            end
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    mem_rsp_valid_i = 1'b1;
                    mem_rsp_data_i  = rsp_data;
                end
            end
            if (mem_req_valid_o && stall_left > 0) begin
                mem_req_ready_i = 1'b0;
                stall_left--;
            end else begin
                mem_req_ready_i = mem_req_valid_o;
            end
        end
    end

    // Output monitor: pops scoreboard entries and checks protocol-level properties.
    always @(negedge clk_i) begin : monitor
        exp_t e;
        logic            hold_pend;
        logic [PA_W-1:0] hold_addr;
        logic            after_out;
        cyc++;
        if (cyc == 1) begin
            hold_pend = 1'b0;
            hold_addr = '0;
            after_out = 1'b0;
        end
        if (!update_o[62]) check("upd_zero", 64'(update_o), 64'd0);
        if (hold_pend) begin
            check("req_hold_v", 64'(mem_req_valid_o), 64'd1);
            check("req_hold_a", 64'(mem_req_addr_o), 64'(hold_addr));
        end
        hold_pend = mem_req_valid_o && !mem_req_ready_i && !rst_i && !flush_i;
        hold_addr = mem_req_addr_o;
        if (mem_req_valid_o && mem_req_ready_i && !rst_i) begin
            n_req_seen++;
            if (exp_req_q.size() > 0) check("req_addr", 64'(mem_req_addr_o), 64'(exp_req_q.pop_front()));
        end
        if (update_o[62] || fault_o) begin
            n_out_seen++;
            check("out_lat", 64'(cyc), 64'(last_rsp_cyc + 1));
            if (exp_out_q.size() > 0) begin
                e = exp_out_q.pop_front();
                check("update", 64'(update_o), 64'(e.upd));
                check("fault", 64'(fault_o), 64'(e.flt));
                if (e.flt) check("fault_va", 64'(fault_vaddr_o), 64'(e.fva));
            end
            after_out = 1'b1;
        end else if (after_out) begin
            check("ready_after", 64'(miss_ready_o), 64'(!flush_i));
            after_out = 1'b0;
        end
        if (mem_rsp_valid_i) last_rsp_cyc = cyc;
    end

    // Called just after a posedge; returns at the negedge of the first request cycle.
    task automatic issue_miss(input logic [21:0] satp, input logic [31:0] va, input logic [8:0] asid);
        miss_valid_i = 1'b1;
        miss_vaddr_i = va;
        miss_asid_i  = asid;
        satp_ppn_i   = satp;
        @(negedge clk_i);
        check("miss_ready", 64'(miss_ready_o), 64'd1);
        @(posedge clk_i);
        #1;
        miss_valid_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic wait_idle(input string tag);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(posedge clk_i);
            #1;
            if (exp_out_q.size() == 0 && exp_req_q.size() == 0 && rsp_cnt == 0 && miss_ready_o)
                done = 1'b1;
        end
        repeat (3) begin
            @(posedge clk_i);
            #1;
        end
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_reqs"}, 64'(n_req_seen), 64'(n_req_exp));
        check({tag, "_outs"}, 64'(n_out_seen), 64'(n_out_exp));
    endtask

    // Reference walk: builds the page table, queues expected requests and result, then runs it.
    task automatic walk(input string tag, input logic [21:0] satp, input logic [31:0] va,
                        input logic [8:0] asid, input logic [31:0] p1, input logic [31:0] p0_in,
                        input int stall);
        logic [PA_W-1:0] a1, a0;
        logic [31:0]     p0;
        exp_t            e;
        bit              l1_bad, l1_leaf;
        p0 = p0_in;
        a1 = PA_W'(satp) * 34'd4096 + PA_W'(va[31:22]) * 34'd4;
        mem[a1] = p1;
        exp_req_q.push_back(a1);
        n_req_exp++;
        e.upd   = '0;
        e.flt   = 1'b0;
        e.fva   = va;
        l1_bad  = !p1[0] || (!p1[1] && p1[2]);
        l1_leaf = p1[1] || p1[3];
        if (l1_bad || (l1_leaf && p1[19:10] != 10'd0)) begin
            e.flt = 1'b1;
        end else if (l1_leaf) begin
            e.upd = {1'b1, 1'b1, va[31:12], asid, p1};
        end else begin
            a0 = PA_W'(p1[31:10]) * 34'd4096 + PA_W'(va[21:12]) * 34'd4;
            if (a0 == a1) p0 = p1;
            mem[a0] = p0;
            exp_req_q.push_back(a0);
            n_req_exp++;
            if (!p0[0] || (!p0[1] && p0[2]) || !(p0[1] || p0[3])) e.flt = 1'b1;
            else e.upd = {1'b1, 1'b0, va[31:12], asid, p0};
        end
        exp_out_q.push_back(e);
        n_out_exp++;
        stall_cfg  = stall;
        stall_left = stall;
        issue_miss(satp, va, asid);
        check({tag, "_req_lat"}, 64'(mem_req_valid_o), 64'd1);
        wait_idle(tag);
    endtask

    task automatic flush_l0_test();
        bit found, seen_rsp;
        mem[34'h80004] = 32'h00020C01;
        mem[34'h8300C] = 32'h048D140F;
        exp_req_q.push_back(34'h80004);
        exp_req_q.push_back(34'h8300C);
        n_req_exp += 2;
        rsp_lat    = 3;
        stall_cfg  = 0;
        stall_left = 0;
        issue_miss(22'h00080, 32'h00403000, 9'd1);
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            if (mem_req_valid_o && mem_req_ready_i && mem_req_addr_o == 34'h8300C) found = 1'b1;
            else @(negedge clk_i);
        end
        check("flush_l0_seen", 64'(found), 64'd1);
        @(posedge clk_i);
        #1;
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        seen_rsp = 1'b0;
        for (int k = 0; k < 20 && !seen_rsp; k++) begin
            @(negedge clk_i);
            if (mem_rsp_valid_i) seen_rsp = 1'b1;
        end
        check("flush_rsp_seen", 64'(seen_rsp), 64'd1);
        check("drain_ready", 64'(miss_ready_o), 64'd0);
        @(negedge clk_i);
        check("drain_exit", 64'(miss_ready_o), 64'd1);
        @(posedge clk_i);
        #1;
        rsp_lat = 1;
        wait_idle("flush_l0");
    endtask

    initial begin : main
        logic [31:0] va, p1, p0;
        logic [21:0] satp;
        logic [8:0]  asid;
        int          kind;
        rst_i        = 1'b1;
        miss_valid_i = 1'b0;
        miss_vaddr_i = 32'h0;
        miss_asid_i  = '0;
        satp_ppn_i   = 22'h0;
        flush_i      = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_ready", 64'(miss_ready_o), 64'd1);
        check("rst_req_v", 64'(mem_req_valid_o), 64'd0);
        check("rst_req_a", 64'(mem_req_addr_o), 64'd0);
        check("rst_update", 64'(update_o), 64'd0);
        check("rst_fault", 64'(fault_o), 64'd0);
        check("rst_fault_va", 64'(fault_vaddr_o), 64'd0);
        @(posedge clk_i);
        #1;

        walk("ptr_4k", 22'h00080, 32'h00403000, 9'd1, 32'h00020C01, 32'h048D140F, 0);
        walk("super", 22'h00080, 32'h00403000, 9'd1, 32'h2000000F, 32'h0, 0);
        walk("misalign", 22'h00080, 32'h00403000, 9'd1, 32'h20000C0F, 32'h0, 0);
        walk("inval_l1", 22'h00080, 32'h00403000, 9'd1, 32'h00000000, 32'h0, 0);
        walk("backpress", 22'h00080, 32'h00403000, 9'd1, 32'h00020C01, 32'h048D140F, 3);
        walk("wnr_l1", 22'h00123, 32'hFFC01000, 9'h1FF, 32'h00000005, 32'h0, 1);
        walk("ptr_l0", 22'h00080, 32'h00403000, 9'd7, 32'h00020C01, 32'h00020C01, 0);
        walk("inval_l0", 22'h3FFFFF, 32'h80000FFF, 9'h0AA, 32'h00020C01, 32'h048D1406, 2);

        flush_l0_test();

        // A miss offered during a flush must not be taken.
        flush_i      = 1'b1;
        miss_valid_i = 1'b1;
        miss_vaddr_i = 32'h12345000;
        @(negedge clk_i);
        check("idle_flush_ready", 64'(miss_ready_o), 64'd0);
        @(posedge clk_i);
        #1;
        flush_i      = 1'b0;
        miss_valid_i = 1'b0;
        @(negedge clk_i);
        check("idle_flush_noreq", 64'(mem_req_valid_o), 64'd0);
        @(posedge clk_i);
        #1;

        // Synchronous reset in the middle of a stalled request.
        stall_cfg  = 10;
        stall_left = 10;
        issue_miss(22'h00080, 32'h00403000, 9'd1);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("midrst_req_v", 64'(mem_req_valid_o), 64'd0);
        check("midrst_req_a", 64'(mem_req_addr_o), 64'd0);
        check("midrst_ready", 64'(miss_ready_o), 64'd1);
        stall_cfg  = 0;
        stall_left = 0;
        @(posedge clk_i);
        #1;

        for (int i = 0; i < 16; i++) begin
            satp = 22'($urandom);
            va   = $urandom;
            asid = 9'($urandom);
            kind = $urandom_range(0, 3);
            case (kind)
                0:       p1 = {22'($urandom), 10'h001};
                1:       p1 = {12'($urandom), 10'h000, 2'($urandom), 4'($urandom), 4'hB};
                2:       p1 = $urandom;
                default: p1 = {22'($urandom), 2'($urandom), 8'h01};
            endcase
            p0      = $urandom | 32'h1;
            rsp_lat = $urandom_range(1, 3);
            walk("rand", satp, va, asid, p1, p0, $urandom_range(0, 2));
        end
        rsp_lat = 1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
